// File: rtl/glay_transactions_issuer.sv
// Splits a beat-counted job into 4 KB-safe bursts and tracks bursts in flight.
// Optional counters (stall_cycles, burst_count) exist when GLAY_TRANSACTIONS_ISSUER_STATS_EN is defined.
module glay_transactions_issuer #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_LEN_WIDTH       = 32,
    parameter int C_BYTES_PER_BEAT  = 64,
    parameter int C_MAX_BURST       = 64,
    parameter int C_MAX_OUTSTANDING = 16,
    localparam int OW = $clog2(C_MAX_OUTSTANDING) + 1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_clken,
    input  logic                    start,
    input  logic [C_ADDR_WIDTH-1:0] base_addr,
    input  logic [C_LEN_WIDTH-1:0]  total_beats,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [C_ADDR_WIDTH-1:0] req_addr,
    output logic [7:0]              req_len,
    input  logic                    rsp_valid,
    output logic [OW-1:0]           outstanding,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
    output logic [31:0]             stall_cycles,
    output logic [31:0]             burst_count,
`endif
    output logic [1:0]              dbg_state_o
);

    // Valid/ready: a request transfers on a cycle with req_valid && req_ready && ap_clken;
    // from the cycle req_valid rises, req_valid/req_addr/req_len hold until that transfer.

    localparam int BPB_LOG2 = $clog2(C_BYTES_PER_BEAT);
    localparam int CW       = (C_LEN_WIDTH > 13) ? C_LEN_WIDTH : 13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [OW-1:0]           outstanding_q, outstanding_d;
    logic                    err_q, err_d;

`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bursts_q, bursts_d;
`endif

    logic [12:0]             bytes_to_4k;
    logic [CW-1:0]           beats_to_4k;
    logic [CW-1:0]           rem_ext;
    logic [CW-1:0]           burst_beats;
    logic [C_ADDR_WIDTH-1:0] addr_inc;
    logic                    hs;
    logic                    rsp;

    // Burst size is the tightest of remaining work, burst cap and the 4 KB page edge.
    assign bytes_to_4k = 13'h1000 - {1'b0, addr_q[11:0]};
    assign beats_to_4k = CW'(bytes_to_4k >> BPB_LOG2);
    assign rem_ext     = CW'(remaining_q);

    always_comb begin
        burst_beats = CW'(C_MAX_BURST);
        if (beats_to_4k < burst_beats) burst_beats = beats_to_4k;
        if (rem_ext < burst_beats)     burst_beats = rem_ext;
    end

    assign addr_inc  = C_ADDR_WIDTH'(burst_beats) << BPB_LOG2;
    assign req_valid = (state_q == S_ISSUE) && (remaining_q != '0) &&
                       (outstanding_q < OW'(C_MAX_OUTSTANDING));
    assign req_addr  = addr_q;
    assign req_len   = req_valid ? 8'(burst_beats - CW'(1)) : 8'd0;
    assign hs        = ap_clken && req_valid && req_ready;
    assign rsp       = ap_clken && rsp_valid;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;
`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
        stall_d       = stall_q;
        bursts_d      = bursts_q;
`endif
        if (ap_clken) begin
            if (state_q == S_IDLE && start) begin
                err_d = 1'b0;
`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
                stall_d  = '0;
                bursts_d = '0;
`endif
                if (total_beats != '0) begin
                    addr_d      = base_addr;
                    remaining_d = total_beats;
                end
            end

            if (hs) begin
                addr_d      = addr_q + addr_inc;
                remaining_d = remaining_q - C_LEN_WIDTH'(burst_beats);
            end

`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
            if (hs && bursts_q != '1) bursts_d = bursts_q + 32'd1;
            if (req_valid && !req_ready && stall_q != '1) stall_d = stall_q + 32'd1;
`endif

            // A response in the same cycle as a handshake cancels the increment.
            if (hs && !rsp) begin
                outstanding_d = outstanding_q + OW'(1);
            end else if (!hs && rsp) begin
                if (outstanding_q != '0) outstanding_d = outstanding_q - OW'(1);
                else                     err_d = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) state_d = (total_beats != '0) ? S_ISSUE : S_DONE;
                end
                S_ISSUE: begin
                    if (remaining_d == '0) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (outstanding_d == '0) state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
            stall_q       <= '0;
            bursts_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
            stall_q       <= stall_d;
            bursts_q      <= bursts_d;
`endif
        end
    end

    assign outstanding = outstanding_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
    assign stall_cycles = stall_q;
    assign burst_count  = bursts_q;
`endif

endmodule

// File: tb/tb_glay_transactions_issuer.sv
// Directed bench for glay_transactions_issuer: burst splitting, 4 KB crossing,
// outstanding limit, backpressure hold, stray responses, clock enable and reset.
module tb_glay_transactions_issuer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_clken;
  logic        start;
  logic [63:0] base_addr;
  logic [31:0] total_beats;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic        rsp_valid;
  logic [4:0]  outstanding;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;
`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] burst_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [71:0] exp_q[$];

  glay_transactions_issuer dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_clken    (ap_clken),
    .start       (start),
    .base_addr   (base_addr),
    .total_beats (total_beats),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .rsp_valid   (rsp_valid),
    .outstanding (outstanding),
    .busy        (busy),
    .done        (done),
    .err         (err),
`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
    .stall_cycles(stall_cycles),
    .burst_count (burst_count),
`endif
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs a job with req_ready=1 and each response one cycle after its handshake;
  // bursts are scored against exp_q.
  task automatic run_job(input string tag, input logic [63:0] base, input logic [31:0] total);
    int   n_exp;
    int   n_seen;
    int   rsp_cyc;
    int   done_cyc;
    logic hs_prev;
    n_exp = exp_q.size();
    n_seen = 0;
    rsp_cyc = -10;
    done_cyc = -1;
    hs_prev = 1'b0;
    start = 1'b1; base_addr = base; total_beats = total; req_ready = 1'b1; rsp_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
      rsp_valid = hs_prev;
      if (hs_prev) rsp_cyc = cyc;
      hs_prev = req_valid;
      if (done) done_cyc = cyc;
      if (req_valid) begin
        n_seen++;
        if (exp_q.size() > 0) check({tag, " burst addr/len"}, {req_addr, req_len}, exp_q.pop_front());
      end
      tick();
    end
    rsp_valid = 1'b0;
    check({tag, " burst count"}, 72'(n_seen), 72'(n_exp));
    check({tag, " done one cycle after last rsp"}, 72'(done_cyc), 72'(rsp_cyc + 1));
    check({tag, " done pulse ends"}, {done, busy}, 72'b00);
    check({tag, " outstanding after job"}, 72'(outstanding), 72'd0);
    check({tag, " err after job"}, 72'(err), 72'd0);
    exp_q.delete();
  endtask

  initial begin : stim
    int hs_cnt;
    ap_rst_n = 1'b0; ap_clken = 1'b1; start = 1'b0; base_addr = '0; total_beats = '0;
    req_ready = 1'b0; rsp_valid = 1'b0;
    @(negedge ap_clk);
    tick(); tick(); tick();

    // reset state
    check("rst req_valid", 72'(req_valid), 72'd0);
    check("rst busy", 72'(busy), 72'd0);
    check("rst done", 72'(done), 72'd0);
    check("rst err", 72'(err), 72'd0);
    check("rst outstanding", 72'(outstanding), 72'd0);
    check("rst req_addr", 72'(req_addr), 72'd0);
    check("rst req_len", 72'(req_len), 72'd0);
    check("rst state", 72'(dbg_state), 72'd0);
    ap_rst_n = 1'b1;
    tick();

    // 200 beats from 0: three full bursts then a short tail
    exp_q.push_back({64'h0000, 8'd63});
    exp_q.push_back({64'h1000, 8'd63});
    exp_q.push_back({64'h2000, 8'd63});
    exp_q.push_back({64'h3000, 8'd7});
    run_job("job200", 64'h0, 32'd200);

    // 4 beats straddling a 4 KB page
    exp_q.push_back({64'h0FC0, 8'd0});
    exp_q.push_back({64'h1000, 8'd2});
    run_job("job4k", 64'hFC0, 32'd4);

    // outstanding limit with responses withheld
    start = 1'b1; base_addr = 64'h0; total_beats = 32'd2000; req_ready = 1'b1;
    tick();
    start = 1'b0;
    hs_cnt = 0;
    for (int i = 0; i < 40 && req_valid; i++) begin
      hs_cnt++;
      tick();
    end
    check("limit handshakes", 72'(hs_cnt), 72'd16);
    check("limit req_valid low", 72'(req_valid), 72'd0);
    check("limit outstanding", 72'(outstanding), 72'd16);
    check("limit req_addr", 72'(req_addr), 72'h10000);

    // start outside IDLE is ignored
    start = 1'b1; base_addr = 64'hAAAA000; total_beats = 32'd5;
    tick();
    start = 1'b0;
    check("start ignored addr", 72'(req_addr), 72'h10000);
    check("start ignored busy", 72'(busy), 72'd1);

    // clock enable low freezes everything, including a response
    ap_clken = 1'b0; rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
    check("clken outstanding", 72'(outstanding), 72'd16);
    check("clken req_valid", 72'(req_valid), 72'd0);
    ap_clken = 1'b1;

    // one response releases exactly one burst
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    hs_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_valid) hs_cnt++;
      tick();
    end
    check("one rsp one burst", 72'(hs_cnt), 72'd1);
    check("one rsp outstanding", 72'(outstanding), 72'd16);
    check("one rsp req_addr", 72'(req_addr), 72'h11000);

    // backpressure: request held stable for 5 stalled cycles
    req_ready = 1'b0; rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall req_valid", 72'(req_valid), 72'd1);
      check("stall addr/len", {req_addr, req_len}, {64'h11000, 8'd63});
      tick();
    end
    check("stall addr/len after", {req_addr, req_len}, {64'h11000, 8'd63});
`ifdef GLAY_TRANSACTIONS_ISSUER_STATS_EN
    check("stall_cycles", 72'(stall_cycles), 72'd5);
    check("burst_count", 72'(burst_count), 72'd17);
`endif
    req_ready = 1'b1;
    tick();
    check("stall release outstanding", 72'(outstanding), 72'd16);
    check("stall release addr", 72'(req_addr), 72'h12000);

    // reset abandons the stuck job
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;

    // reset mid-ISSUE with three bursts in flight
    start = 1'b1; base_addr = 64'h5000; total_beats = 32'd2000; req_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mid outstanding", 72'(outstanding), 72'd3);
    check("mid addr", 72'(req_addr), 72'h8000);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1; req_ready = 1'b0;
    check("midrst state", 72'(dbg_state), 72'd0);
    check("midrst outstanding", 72'(outstanding), 72'd0);
    check("midrst req_valid", 72'(req_valid), 72'd0);
    check("midrst busy", 72'(busy), 72'd0);

    // late response after reset is a stray: err set, count stays 0
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("stray err", 72'(err), 72'd1);
    check("stray outstanding", 72'(outstanding), 72'd0);
    tick();
    check("stray err sticky", 72'(err), 72'd1);

    // zero-length start goes straight to DONE and clears err
    start = 1'b1; base_addr = 64'h0; total_beats = 32'd0;
    tick();
    start = 1'b0;
    check("zero job done", {done, busy, err}, 72'b110);
    tick();
    check("zero job idle", {done, busy, err}, 72'b000);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/glay_transactions_issuer.md
GLAY_TRANSACTIONS_ISSUER -- requirements
Module: glay_transactions_issuer

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
 - C_ADDR_WIDTH, 64, byte address width.
 - C_LEN_WIDTH, 32, total-beats width.
 - C_BYTES_PER_BEAT, 64, bytes per beat (power of 2).
 - C_MAX_BURST, 64, max beats per burst (1..256).
 - C_MAX_OUTSTANDING, 16, max issued-but-unanswered bursts.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
 - ap_clk, in, 1, sole clock, rising edge.
 - ap_rst_n, in, 1, reset, synchronous, active-low.
 - ap_clken, in, 1, clock enable; low freezes all state.
 - start, in, 1, begin job (sampled in IDLE only).
 - base_addr, in, C_ADDR_WIDTH, beat-aligned job start address.
 - total_beats, in, C_LEN_WIDTH, job length in beats.
 - req_valid, out, 1, burst request valid.
 - req_ready, in, 1, downstream accepts request.
 - req_addr, out, C_ADDR_WIDTH, burst start address.
 - req_len, out, 8, burst beats minus one.
 - rsp_valid, in, 1, one burst completed (single-cycle pulse per burst).
 - outstanding, out, $clog2(C_MAX_OUTSTANDING)+1, bursts in flight.
 - busy, out, 1, high outside IDLE.
 - done, out, 1, one-cycle job-complete pulse.
 - err, out, 1, sticky unexpected-response flag.
REQ-003 The issuer SHALL use one clock and a synchronous active-low reset: ap_clk and ap_rst_n.

Function
REQ-004 States SHALL be IDLE, ISSUE, DRAIN, DONE; all transitions SHALL occur only on cycles with ap_clken high.
REQ-005 IDLE: start with total_beats>0 SHALL capture base_addr/total_beats and enter ISSUE next cycle; start with total_beats==0 SHALL enter DONE directly.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 ISSUE: req_valid SHALL be high iff remaining>0 and outstanding<C_MAX_OUTSTANDING.
REQ-008 Burst beats SHALL equal min(remaining, C_MAX_BURST, beats to next 4 KB boundary); req_len = beats-1.
REQ-009 Once req_valid is high, req_valid/req_addr/req_len SHALL hold stable until req_ready is sampled high.
REQ-010 On handshake: req_addr += beats*C_BYTES_PER_BEAT, remaining -= beats, outstanding += 1; next request may issue the following cycle (one burst per cycle max).
REQ-011 rsp_valid with outstanding>0 SHALL decrement outstanding; simultaneous handshake and rsp_valid SHALL leave outstanding unchanged.
REQ-012 rsp_valid with outstanding==0 and no same-cycle handshake SHALL set err and leave outstanding at 0; err clears only on reset or next accepted start.
REQ-013 ISSUE SHALL go to DRAIN when remaining reaches 0; DRAIN SHALL go to DONE when outstanding reaches 0 (including same-cycle final response).
REQ-014 DONE SHALL assert done for exactly one cycle and return to IDLE; busy low in IDLE only.
REQ-015 Address arithmetic SHALL wrap modulo 2^C_ADDR_WIDTH without error.

Reset
REQ-016 While ap_rst_n low at a rising edge: state IDLE; req_valid, busy, done, err = 0; outstanding = 0; req_addr, req_len = 0; reset SHALL take priority over ap_clken.
REQ-017 Reset mid-job SHALL abandon the job; responses arriving afterwards SHALL be treated per REQ-012.

Configuration
REQ-018 Macro GLAY_TRANSACTIONS_ISSUER_STATS_EN defined: extra outputs stall_cycles (32 bit, counts ISSUE cycles with req_valid & ~req_ready) and burst_count (32 bit, accepted bursts), cleared on reset and on accepted start, saturating at max. Undefined: these ports and counters SHALL not exist; other behaviour identical.

Verification
REQ-019 base_addr=0x0, total_beats=200, req_ready=1, immediate rsp: bursts 64,64,64,8 at 0x0,0x1000,0x2000,0x3000; done one cycle after last rsp.
REQ-020 base_addr=0xFC0, total_beats=4: first burst req_len=0 at 0xFC0, second req_len=2 at 0x1000.
REQ-021 total_beats=2000, rsp withheld: req_valid drops after 16 handshakes, outstanding=16; one rsp -> exactly one more burst issued.
REQ-022 req_ready low 5 cycles with req_valid high: req_addr/req_len unchanged; stall_cycles=5 when STATS_EN defined.
REQ-023 rsp_valid pulse in IDLE: err=1, outstanding=0; next start clears err.
REQ-024 ap_rst_n low mid-ISSUE with outstanding=3: next cycle IDLE, outstanding=0, req_valid=0, busy=0.
